// File: rtl/rvfi_sched_pkg.sv
// Shared types for the RVFI retirement scheduler.
// Entry layout carried through the FIFO and the FSM state encoding.
// No logic here; widths are fixed by the package constants.
package rvfi_sched_pkg;

  // Register/PC width of the checked core (the XLEN the entry pc is built with).
  localparam int SCHED_XLEN = 32;

  // Width of the RVFI order field carried per entry.
  localparam int ORDER_W = 8;

  // Width of an instruction word.
  localparam int INSN_W = 32;

  typedef struct packed {
    logic [ORDER_W-1:0]    order;
    logic [INSN_W-1:0]     insn;
    logic [SCHED_XLEN-1:0] pc;
  } rvfi_sched_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } rvfi_sched_state_t;

endpackage

// File: rtl/rvfi_sched_fifo.sv
// Multi-write (up to NRET per cycle), single-read entry storage with occupancy count.
// Latency: a write becomes readable at the head on the following cycle.
// Backpressure: none internally; the caller only writes when wr_n fits in free space.
module rvfi_sched_fifo
  import rvfi_sched_pkg::*;
#(
  parameter int  NRET  = 2,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  rvfi_sched_entry_t wr_data [NRET],
  input  logic [CW-1:0]     wr_n,
  input  logic              rd_en,
  output rvfi_sched_entry_t rd_data,
  output logic [CW-1:0]     count
);

  rvfi_sched_entry_t mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Storage and pointers: compacted entries land at consecutive slots from the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NRET; i++) begin
        if (CW'(i) < wr_n) begin
          mem[wr_ptr + PW'(i)] <= wr_data[i];
        end
      end
      wr_ptr <= wr_ptr + PW'(wr_n);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + wr_n - CW'(rd_en);
    end
  end

  // Head is read straight from storage so the consumer sees no path from the inputs.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rvfi_imem_sched.sv
// Serialises the multi-channel RVFI retire bundle into one in-order stream, oldest channel first.
// Latency: 1 cycle from retire to chk_* at the earliest; one pop per cycle.
// Backpressure: chk_ready stalls the head; a group that does not fit is dropped, flags overflow and halts.
// Optional order-gap checking is compiled in with RVFI_IMEM_SCHED_ORDER_CHECK_EN.
module rvfi_imem_sched
  import rvfi_sched_pkg::*;
#(
  parameter int  XLEN  = 32,
  parameter int  NRET  = 2,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*8-1:0]      rvfi_order,
  input  logic [NRET*32-1:0]     rvfi_insn,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  output logic                   chk_valid,
  input  logic                   chk_ready,
  output logic [7:0]             chk_order,
  output logic [31:0]            chk_insn,
  output logic [XLEN-1:0]        chk_pc,
  output logic                   overflow,
  output logic                   order_err
);

  rvfi_sched_state_t state;
  rvfi_sched_state_t state_nxt;

  rvfi_sched_entry_t comp [NRET];
  rvfi_sched_entry_t head;
  logic [CW-1:0]     n;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [CW-1:0]     wr_n;
  logic              push_en;
  logic              accept;
  logic              drop;
  logic              pop;
  logic              ord_mismatch;

  // Compact valid channels into consecutive slots, preserving channel (age) order.
  always_comb begin
    int slot;
    slot = 0;
    for (int i = 0; i < NRET; i++) begin
      comp[i] = '0;
    end
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        comp[slot].order = rvfi_order[k*8 +: 8];
        comp[slot].insn  = rvfi_insn[k*32 +: 32];
        comp[slot].pc    = SCHED_XLEN'(rvfi_pc_rdata[k*XLEN +: XLEN]);
        slot = slot + 1;
      end
    end
    n = CW'(slot);
  end

  // Whole-group accept or drop against the pre-pop free space; never a partial push.
  always_comb begin
    free   = CW'(DEPTH) - count;
    accept = push_en && (n != '0) && (n <= free);
    drop   = push_en && (n != '0) && (n > free);
    wr_n   = accept ? n : '0;
    pop    = chk_valid && chk_ready;
  end

  rvfi_sched_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (comp),
    .wr_n    (wr_n),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign chk_valid = (count != '0);
  assign chk_order = head.order;
  assign chk_insn  = head.insn;
  assign chk_pc    = XLEN'(head.pc);

  // FSM state register; HALT is only left through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a dropped group or an order gap stops intake for good.
  always_comb begin
    state_nxt = state;
    if (state == RUN && (drop || ord_mismatch)) begin
      state_nxt = HALT;
    end
  end

  // FSM outputs: only RUN admits new retire groups; the FIFO drains in either state.
  always_comb begin
    push_en = (state == RUN);
  end

  // Sticky overflow flag, raised the cycle after a group is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef RVFI_IMEM_SCHED_ORDER_CHECK_EN
  logic [7:0] expected;
  logic       exp_vld;

  // The first pop only primes the expectation; later pops must follow it exactly.
  assign ord_mismatch = pop && exp_vld && (chk_order != expected);

  // Expected-order tracking; the 255->0 wrap falls out of the 8-bit add.
  always_ff @(posedge clk) begin
    if (reset) begin
      expected  <= '0;
      exp_vld   <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (pop) begin
        expected <= chk_order + 8'd1;
        exp_vld  <= 1'b1;
      end
      if (ord_mismatch) begin
        order_err <= 1'b1;
      end
    end
  end
`else
  assign ord_mismatch = 1'b0;
  assign order_err    = 1'b0;
`endif

endmodule
